// File: rtl/matrix_pkg.sv
// Shared constants, result-width derivation and FSM state encoding for the
// 3x3 matrix multiply engine.
package matrix_pkg;

  localparam int MAT_N      = 3;
  localparam int NUM_BYTES  = 2 * MAT_N * MAT_N;
  localparam int DATA_W_DEF = 8;

  // Two extra bits hold the sum of three full-scale products without wrap.
  function automatic int res_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_mult_engine_if.sv
// Request/result bundle between the operand buffer, the engine and the
// downstream result consumer.
interface matrix_mult_engine_if
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int RES_W = res_w(DATA_W);

  logic                        start;
  logic [NUM_BYTES*DATA_W-1:0] operands;
  logic [RES_W-1:0]            res_data;
  logic                        res_valid;
  logic                        res_ready;
  logic [3:0]                  res_index;
  logic                        busy;
  logic                        done;

  modport master (
    output start, operands, res_ready,
    input  res_data, res_valid, res_index, busy, done
  );

  modport slave (
    input  start, operands, res_ready,
    output res_data, res_valid, res_index, busy, done
  );

endinterface

// File: rtl/matrix_mult_engine_mac_unit.sv
// Single multiply-accumulate lane: one DATA_W x DATA_W product per enabled
// cycle summed into a RES_W accumulator, with a synchronous clear.
module mac_unit
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = res_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod_s;

  assign prod_s = a * b;

  // Accumulator register; clear has priority over accumulate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= {RES_W{1'b0}};
    end else if (clr) begin
      acc <= {RES_W{1'b0}};
    end else if (en) begin
      acc <= acc + RES_W'(prod_s);
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// 3x3 unsigned matrix multiplier: latches both operand matrices on start and
// streams C = A x B out row-major, one element per valid/ready handshake.
module matrix_mult_engine
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  matrix_mult_engine_if.slave bus
);

  localparam int RES_W = res_w(DATA_W);

  state_t            state_r;
  state_t            state_s;
  logic [1:0]        k_r;
  logic [1:0]        row_r;
  logic [1:0]        col_r;
  logic [3:0]        idx_r;
  logic              busy_r;
  logic              valid_r;
  logic              done_r;
  logic [DATA_W-1:0] op_r [NUM_BYTES];

  logic              load_s;
  logic              clr_s;
  logic              en_s;
  logic              hs_s;
  logic              last_k_s;
  logic              last_idx_s;
  logic [4:0]        a_idx_s;
  logic [4:0]        b_idx_s;
  logic [RES_W-1:0]  acc_s;

  assign hs_s       = valid_r && bus.res_ready;
  assign last_k_s   = (k_r == 2'd2);
  assign last_idx_s = (idx_r == 4'd8);

  // A is walked along row i, B down column j; B starts at byte 9.
  assign a_idx_s = 5'(row_r) * 5'd3 + 5'(k_r);
  assign b_idx_s = 5'd9 + 5'(k_r) * 5'd3 + 5'(col_r);

  mac_unit #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (en_s),
    .a     (op_r[a_idx_s]),
    .b     (op_r[b_idx_s]),
    .acc   (acc_s)
  );

  // Operand capture; only the start edge in IDLE loads new matrices.
  always_ff @(posedge clk) begin
    if (load_s) begin
      for (int n = 0; n < NUM_BYTES; n++) begin
        op_r[n] <= bus.operands[DATA_W*n +: DATA_W];
      end
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_MAC;
          load_s  = 1'b1;
          clr_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        en_s = 1'b1;
        if (last_k_s) begin
          state_s = ST_OUT;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_OUT: begin
        if (hs_s && last_idx_s) begin
          state_s = ST_FIN;
        end else if (hs_s) begin
          state_s = ST_MAC;
          clr_s   = 1'b1;
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      k_r     <= 2'd0;
      row_r   <= 2'd0;
      col_r   <= 2'd0;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_OUT);
      done_r  <= (state_s == ST_FIN);
      if (load_s) begin
        k_r   <= 2'd0;
        row_r <= 2'd0;
        col_r <= 2'd0;
        idx_r <= 4'd0;
      end else if (en_s) begin
        k_r <= last_k_s ? 2'd0 : k_r + 2'd1;
      end else if (hs_s && !last_idx_s) begin
        k_r   <= 2'd0;
        idx_r <= idx_r + 4'd1;
        if (col_r == 2'd2) begin
          col_r <= 2'd0;
          row_r <= row_r + 2'd1;
        end else begin
          col_r <= col_r + 2'd1;
        end
      end
    end
  end

  assign bus.res_data  = acc_s;
  assign bus.res_valid = valid_r;
  assign bus.res_index = idx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Self-checking bench for matrix_mult_engine: directed and random matrices
// compared against a plain-arithmetic product model, plus reset corner cases.
module tb_matrix_mult_engine;
  import matrix_pkg::*;

  localparam int DW = 8;
  localparam int RW = 18;

  typedef struct {
    logic [9*DW-1:0] a;
    logic [9*DW-1:0] b;
    logic [9*RW-1:0] c;
    int              stall_elem;
    bit              disturb;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  matrix_mult_engine_if #(.DATA_W(DW)) bus ();

  matrix_mult_engine #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in plain integer arithmetic.
  function automatic logic [9*RW-1:0] model(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b);
    logic [9*RW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) begin
          s += int'(a[(i*3+k)*DW +: DW]) * int'(b[(k*3+j)*DW +: DW]);
        end
        r[(i*3+j)*RW +: RW] = RW'(s);
      end
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int n = 0; n < 9; n++) begin
      v.a[n*DW +: DW] = DW'($urandom_range(0, 255));
      v.b[n*DW +: DW] = DW'($urandom_range(0, 255));
    end
    v.c = model(v.a, v.b);
    v.stall_elem = -1;
    v.disturb = 1'b0;
    return v;
  endfunction

  task automatic run_matrix(input vec_t v);
    int cycles;
    int bad_done;
    logic [RW-1:0] hold_d;
    logic [3:0] hold_i;
    bad_done = 0;
    bus.operands = {v.b, v.a};
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (v.disturb) bus.operands = ~{v.b, v.a};
    for (int e = 0; e < 9; e++) begin
      if (e == v.stall_elem) bus.res_ready = 1'b0;
      cycles = 0;
      while (bus.res_valid !== 1'b1 && cycles < 20) begin
        if (v.disturb && e == 0 && cycles == 1) bus.start = 1'b1;
        else bus.start = 1'b0;
        @(negedge clk);
        cycles++;
        if (bus.done === 1'b1) bad_done++;
      end
      bus.start = 1'b0;
      if (cycles >= 20) begin
        chk("valid_timeout", cycles, 3);
        bus.res_ready = 1'b1;
        return;
      end
      chk("latency", cycles, 3);
      chk("index", bus.res_index, e);
      chk("data", bus.res_data, v.c[e*RW +: RW]);
      if (e == v.stall_elem) begin
        hold_d = bus.res_data;
        hold_i = bus.res_index;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", bus.res_valid, 1);
          chk("stall_data", bus.res_data, hold_d);
          chk("stall_index", bus.res_index, hold_i);
        end
        bus.res_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_drop", bus.res_valid, 0);
    end
    chk("done_pulse", bus.done, 1);
    chk("fin_busy", bus.busy, 1);
    if (v.disturb) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_clear", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("no_early_done", bad_done, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.res_valid, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_data"}, bus.res_data, 0);
    chk({tag, "_index"}, bus.res_index, 0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int exp1[9];
    int cycles;
    int glitch;
    exp1 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    for (int n = 0; n < 9; n++) begin
      tbl[0].a[n*DW +: DW] = DW'(n + 1);
      tbl[0].b[n*DW +: DW] = DW'(9 - n);
      tbl[0].c[n*RW +: RW] = RW'(exp1[n]);
      tbl[1].a[n*DW +: DW] = (n == 0 || n == 4 || n == 8) ? 8'd1 : 8'd0;
      tbl[1].b[n*DW +: DW] = DW'(10 + n);
      tbl[1].c[n*RW +: RW] = RW'(10 + n);
      tbl[2].a[n*DW +: DW] = 8'd255;
      tbl[2].b[n*DW +: DW] = 8'd255;
      tbl[2].c[n*RW +: RW] = 18'd195075;
    end
    tbl[0].stall_elem = -1; tbl[0].disturb = 1'b0;
    tbl[1].stall_elem = -1; tbl[1].disturb = 1'b0;
    tbl[2].stall_elem = -1; tbl[2].disturb = 1'b0;
    tbl[3] = tbl[0];
    tbl[3].stall_elem = 4;
    tbl[4] = rand_vec();
    tbl[4].disturb = 1'b1;
    for (int t = 5; t < 8; t++) tbl[t] = rand_vec();
    tbl[6].stall_elem = 8;

    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    bus.operands = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_no_effect", bus.res_valid, 0);

    for (int t = 0; t < 8; t++) run_matrix(tbl[t]);

    // Reset during MAC of element 2 abandons the run.
    v = rand_vec();
    bus.operands = {v.b, v.a};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (bus.res_index !== 4'd2 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 40) chk("idx2_timeout", cycles, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    chk_zero("held_rst");
    reset = 1'b1;
    glitch = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) glitch++;
    end
    chk("post_rst_quiet", glitch, 0);
    run_matrix(rand_vec());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_mult_engine.md
MATRIX_MULT_ENGINE -- requirements
Module: matrix_mult_engine

Interface
REQ-001 Parameter: DATA_W, default 8, unsigned operand width; accumulator/result width RES_W = 2*DATA_W+2 (18 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin; driven by the upstream buffer's done.
REQ-005 operands  input  18*DATA_W  flattened operand bytes; byte n = operands[DATA_W*n +: DATA_W]; bytes 0-8 = A row-major, bytes 9-17 = B row-major.
REQ-006 res_data  output  RES_W  current result element C[i][j].
REQ-007 res_valid  output  1  res_data is valid.
REQ-008 res_ready  input  1  downstream accepts res_data.
REQ-009 res_index  output  4  row-major index (0-8) of the element on res_data.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after element 8 is accepted.

Function
REQ-012 The block SHALL compute C = A x B for 3x3 unsigned matrices: C[i][j] = sum over k=0..2 of A[i][k]*B[k][j], with no truncation.
REQ-013 FSM states SHALL be IDLE, MAC, OUT and FIN.
REQ-014 IDLE: at a clock edge with start=1, the block SHALL latch all 18 operand bytes, clear the accumulator, set element index to 0 and k to 0, and go to MAC.
REQ-015 Operands SHALL be sampled only at the start edge; later changes on operands SHALL NOT affect the result.
REQ-016 MAC: each cycle SHALL add one product A[i][k]*B[k][j] and increment k; after the k=2 edge, the FSM SHALL go to OUT.
REQ-017 OUT: res_valid=1, and res_data/res_index SHALL stay stable until a res_valid&&res_ready edge.
REQ-018 On a handshake in OUT with index<8, the block SHALL increment the index, clear the accumulator and k, and return to MAC; with index=8, it SHALL go to FIN.
REQ-019 FIN: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: first res_valid SHALL rise 3 cycles after the start edge; each subsequent element SHALL appear 3 cycles after the previous handshake.
REQ-021 Output order SHALL be row-major: C[0][0], C[0][1], ..., C[2][2].
REQ-022 start SHALL be ignored whenever the FSM is not IDLE, including a start in the FIN cycle.
REQ-023 res_ready while res_valid=0 SHALL have no effect.
REQ-024 Maximum result 3*(2^DATA_W-1)^2 SHALL fit in RES_W bits without wrap.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE and res_valid=0, done=0, busy=0, res_data=0, res_index=0, with accumulator, k and index cleared.
REQ-026 Reset asserted mid-MAC or mid-OUT SHALL abandon the computation; no partial element or done pulse SHALL appear after reset is released.
REQ-027 Latched operand registers need no reset value.

Structure
REQ-028 Shared package matrix_pkg SHALL hold MAT_N=3, NUM_BYTES=18, DATA_W default, the RES_W derivation, and the FSM state enum.
REQ-029 One sub-module, mac_unit, SHALL hold the DATA_W x DATA_W multiplier and RES_W accumulator with clear and enable inputs; the parent SHALL keep the FSM, the counters and operand selection.
REQ-030 Target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-031 A = 1..9 and B = 9..1 (row-major), res_ready=1 -> outputs 30,24,18,84,69,54,138,114,90 at indices 0-8; first res_valid 3 cycles after start; done pulses once.
REQ-032 A = identity, B = 10..18 -> outputs equal B exactly (10..18).
REQ-033 All operand bytes = 255 -> every output = 195075 with no overflow.
REQ-034 Backpressure: res_ready held low for 5 cycles at element 4 -> res_data, res_index and res_valid stay stable, the value is accepted on the first ready cycle, and the sequence completes correctly.
REQ-035 start re-pulsed during MAC with different operands, and operands changed after the start edge -> results still reflect the originally latched operands; no restart occurs.
REQ-036 reset asserted during MAC of element 2, then a new start -> all outputs are 0 during reset, and the new run produces all 9 correct elements starting at index 0.
